// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and default widths for the fetch/exec pipeline.
// Entry layout is instruction word followed by its PC.
package cpu_pkg;

    localparam int CPU_ADDR_BITS  = 8;
    localparam int CPU_INSTR_BITS = 16;
    localparam int CPU_FIFO_DEPTH = 4;

    typedef enum logic {
        S_RUN,
        S_REDIRECT
    } fetch_state_t;

    typedef struct packed {
        logic [CPU_INSTR_BITS-1:0] instr;
        logic [CPU_ADDR_BITS-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem read port, instruction handshake and redirect bundle.
// master = fetch side, slave = memory/exec side.
interface fetch_unit_if #(
    parameter int ADDR_BITS  = 8,
    parameter int INSTR_BITS = 16
);
    logic                  imem_rd_en;
    logic [ADDR_BITS-1:0]  imem_addr;
    logic [INSTR_BITS-1:0] imem_rdata;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [INSTR_BITS-1:0] instr_data;
    logic [ADDR_BITS-1:0]  instr_pc;
    logic                  redirect_valid;
    logic [ADDR_BITS-1:0]  redirect_pc;

    modport master (
        output imem_rd_en, imem_addr,
        input  imem_rdata,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_rd_en, imem_addr,
        output imem_rdata,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: power-of-two prefetch buffer of fetch entries.
// flush empties it in one cycle and overrides push/pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);
    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, epoch-tagged imem reads and prefetch buffer.
// Define FETCH_STATS_EN to add stall_cycles/redirect_count outputs.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_BITS  = CPU_ADDR_BITS,
    parameter int INSTR_BITS = CPU_INSTR_BITS,
    parameter int FIFO_DEPTH = CPU_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] redirect_count
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t         r_state;
    logic [ADDR_BITS-1:0] r_pc;
    logic [ADDR_BITS-1:0] r_inflight_pc;
    logic                 r_inflight;
    logic                 r_inflight_epoch;
    logic                 r_epoch;

    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_issue;
    logic          w_capture;
    logic          w_pop;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_entry;

    // Credit counts the in-flight read so the buffer can never overflow.
    assign w_issue = !reset && (r_state == S_RUN) && !bus.redirect_valid
                   && ((w_count + CW'(r_inflight)) < CW'(FIFO_DEPTH));
    assign w_capture = r_inflight && (r_inflight_epoch == r_epoch)
                     && !bus.redirect_valid;
    assign w_pop = bus.instr_valid && bus.instr_ready;
    assign w_push_entry = '{instr: bus.imem_rdata, pc: r_inflight_pc};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_RUN;
            r_pc             <= '0;
            r_epoch          <= 1'b0;
            r_inflight       <= 1'b0;
            r_inflight_pc    <= '0;
            r_inflight_epoch <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc    <= r_pc;
                r_inflight_epoch <= r_epoch;
                r_pc             <= r_pc + ADDR_BITS'(1);
            end
            if (bus.redirect_valid) begin
                r_pc    <= bus.redirect_pc;
                r_epoch <= ~r_epoch;
                r_state <= S_REDIRECT;
            end else begin
                r_state <= S_RUN;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_capture && !w_full),
        .push_data(w_push_entry),
        .pop      (w_pop),
        .flush    (bus.redirect_valid),
        .head     (w_head),
        .count    (w_count),
        .full     (w_full),
        .empty    (w_empty)
    );

    assign bus.imem_rd_en  = w_issue;
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = !w_empty;
    assign bus.instr_data  = w_empty ? '0 : w_head.instr;
    assign bus.instr_pc    = w_empty ? '0 : w_head.pc;

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            if (bus.instr_ready && !bus.instr_valid && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (bus.redirect_valid && redirect_count != 16'hFFFF)
                redirect_count <= redirect_count + 16'd1;
        end
    end
`endif
endmodule
